// File: rtl/div16_seq_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  // Default operand/result width.
  localparam int DEFAULT_WIDTH = 16;

  // Controller states: waiting for a request, or iterating one bit per cycle.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Bit counter width; it must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div16_seq_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// subtract the divisor when it fits and report the resulting quotient bit.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] dvs_ext;

  // The held remainder is always below the divisor, so its top bit is zero
  // and dropping it while shifting loses nothing.
  assign shifted = (WIDTH+1)'({rem_in, dvd_bit});
  assign dvs_ext = {1'b0, divisor};

  // Compare and conditionally subtract at WIDTH+1 bits.
  always_comb begin
    q_bit   = (shifted >= dvs_ext);
    rem_out = q_bit ? (shifted - dvs_ext) : shifted;
  end

endmodule

// File: rtl/div16_seq.sv
// Sequential unsigned divider: radix-2 restoring algorithm, one quotient bit
// per clock, with a start/busy/done handshake and held result registers.
module div16_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .dvd_bit (dvd_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Next-state logic: accept requests in IDLE, iterate in RUN, publish results
  // only on the final iteration (or immediately for a zero divisor).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            dvd_d   = dividend;
            dvs_d   = divisor;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = CW'(WIDTH);
            busy_d  = 1'b1;
            state_d = RUN;
          end else begin
            // Zero divisor: answer at once with the conventional saturated result.
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
          end
        end
      end
      RUN: begin
        dvd_d = dvd_q << 1;
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          quotient_d  = quo_d;
          remainder_d = step_rem[WIDTH-1:0];
          dbz_d       = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div16_seq.sv
// Directed and random checks for the sequential divider.
module tb_div16_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int checks;
  int failures;

  div16_seq #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and wait for its done. done_edge is the clock edge index
  // (edge 0 = accepting edge) after which done was seen, -1 on timeout.
  task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic z, output int done_edge,
                         output int busy_n, output logic busy_at_done,
                         output logic done_after);
    int k;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    k      = 0;
    busy_n = 0;
    while (!done && k < 40) begin
      if (busy) busy_n++;
      @(negedge clk);
      k++;
    end
    done_edge    = done ? k : -1;
    q            = quotient;
    r            = remainder;
    z            = div_by_zero;
    busy_at_done = busy;
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 35'd0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h z=%b, expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] q, r;
    logic z, bd, da;
    int e, bn;
    run_div(16'd100, 16'd7, q, r, z, e, bn, bd, da);
    checks++;
    if (e !== 16) begin failures++; $display("FAIL basic_latency: got edge %0d, expected 16", e); end
    checks++;
    if ({q, r, z} !== {16'd14, 16'd2, 1'b0}) begin
      failures++; $display("FAIL basic_result: got q=%0d r=%0d z=%b, expected q=14 r=2 z=0", q, r, z);
    end
    checks++;
    if (bn !== 16 || bd !== 1'b0) begin
      failures++; $display("FAIL basic_busy: got busy cycles=%0d busy_at_done=%b, expected 16 and 0", bn, bd);
    end
    checks++;
    if (da !== 1'b0) begin failures++; $display("FAIL basic_done_pulse: done after pulse=%b, expected 0", da); end
    $display("basic 100/7 -> q=%0d r=%0d edge=%0d", q, r, e);
  endtask

  task automatic test_edges();
    logic [15:0] a_tab [3] = '{16'hFFFF, 16'd3, 16'hFFFF};
    logic [15:0] b_tab [3] = '{16'd1, 16'd10, 16'hFFFF};
    logic [15:0] q_tab [3] = '{16'hFFFF, 16'd0, 16'd1};
    logic [15:0] r_tab [3] = '{16'd0, 16'd3, 16'd0};
    logic [15:0] q, r;
    logic z, bd, da;
    int e, bn;
    for (int i = 0; i < 3; i++) begin
      run_div(a_tab[i], b_tab[i], q, r, z, e, bn, bd, da);
      checks++;
      if ({q, r, z} !== {q_tab[i], r_tab[i], 1'b0} || e !== 16) begin
        failures++;
        $display("FAIL edge_%0d: got q=%h r=%h z=%b edge=%0d, expected q=%h r=%h z=0 edge=16",
                 i, q, r, z, e, q_tab[i], r_tab[i]);
      end
      $display("edge %h/%h -> q=%h r=%h", a_tab[i], b_tab[i], q, r);
    end
  endtask

  task automatic test_div_zero();
    logic [15:0] q, r;
    logic z, bd, da;
    int e, bn;
    run_div(16'd5, 16'd0, q, r, z, e, bn, bd, da);
    checks++;
    if ({q, r, z} !== {16'hFFFF, 16'd5, 1'b1} || e !== 0) begin
      failures++;
      $display("FAIL div_zero: got q=%h r=%h z=%b edge=%0d, expected q=ffff r=0005 z=1 edge=0", q, r, z, e);
    end
    checks++;
    if (bn !== 0 || da !== 1'b0) begin
      failures++; $display("FAIL div_zero_busy: got busy cycles=%0d done_after=%b, expected 0 and 0", bn, da);
    end
    $display("div0 5/0 -> q=%h r=%h z=%b", q, r, z);
    run_div(16'd9, 16'd3, q, r, z, e, bn, bd, da);
    checks++;
    if ({q, r, z} !== {16'd3, 16'd0, 1'b0} || e !== 16) begin
      failures++;
      $display("FAIL after_div_zero: got q=%0d r=%0d z=%b edge=%0d, expected q=3 r=0 z=0 edge=16", q, r, z, e);
    end
    $display("after div0 9/3 -> q=%0d r=%0d z=%b", q, r, z);
  endtask

  task automatic test_ignore_start();
    int k, dones;
    @(negedge clk);
    dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    dividend = 16'd50; divisor = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dividend = '0; divisor = '0;
    k = 5;
    while (!done && k < 40) begin @(negedge clk); k++; end
    checks++;
    if ({done, quotient, remainder, div_by_zero} !== {1'b1, 16'd333, 16'd1, 1'b0} || k !== 16) begin
      failures++;
      $display("FAIL ignore_start: got done=%b q=%0d r=%0d z=%b edge=%0d, expected done=1 q=333 r=1 z=0 edge=16",
               done, quotient, remainder, div_by_zero, k);
    end
    dones = 0;
    repeat (20) begin @(negedge clk); if (done) dones++; end
    checks++;
    if (dones !== 0) begin failures++; $display("FAIL ignore_start_extra_done: got %0d dones, expected 0", dones); end
    $display("ignore-start 1000/3 -> q=%0d r=%0d", quotient, remainder);
  endtask

  task automatic test_back_to_back();
    int k;
    @(negedge clk);
    dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 40) begin @(negedge clk); k++; end
    // Request the next division during the done cycle.
    dividend = 16'd50; divisor = 16'd5; start = 1'b1;
    checks++;
    if ({done, quotient, remainder} !== {1'b1, 16'd333, 16'd1}) begin
      failures++; $display("FAIL b2b_first: got done=%b q=%0d r=%0d, expected done=1 q=333 r=1", done, quotient, remainder);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL b2b_accept: got busy=%b done=%b, expected busy=1 done=0", busy, done);
    end
    k = 0;
    while (!done && k < 40) begin @(negedge clk); k++; end
    checks++;
    if ({done, quotient, remainder, div_by_zero} !== {1'b1, 16'd10, 16'd0, 1'b0} || k !== 16) begin
      failures++;
      $display("FAIL b2b_second: got done=%b q=%0d r=%0d z=%b edge=%0d, expected done=1 q=10 r=0 z=0 edge=16",
               done, quotient, remainder, div_by_zero, k);
    end
    $display("back-to-back 50/5 -> q=%0d r=%0d", quotient, remainder);
  endtask

  task automatic test_reset_mid();
    logic [15:0] q, r;
    logic z, bd, da;
    int e, bn, dones;
    @(negedge clk);
    dividend = 16'd40000; divisor = 16'd123; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 35'd0) begin
      failures++;
      $display("FAIL reset_mid: got busy=%b done=%b q=%h r=%h z=%b, expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    dones = 0;
    repeat (3) begin @(negedge clk); if (done) dones++; end
    rst_n = 1'b1;
    repeat (12) begin @(negedge clk); if (done) dones++; end
    checks++;
    if (dones !== 0) begin failures++; $display("FAIL reset_mid_done: got %0d dones, expected 0", dones); end
    run_div(16'd40000, 16'd123, q, r, z, e, bn, bd, da);
    checks++;
    if ({q, r, z} !== {16'd325, 16'd25, 1'b0} || e !== 16) begin
      failures++;
      $display("FAIL reset_rerun: got q=%0d r=%0d z=%b edge=%0d, expected q=325 r=25 z=0 edge=16", q, r, z, e);
    end
    $display("after reset 40000/123 -> q=%0d r=%0d", q, r);
  endtask

  task automatic test_random();
    logic [15:0] a, b, q, r;
    logic z, bd, da;
    int e, bn;
    logic [31:0] prod;
    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      case (i % 10)
        0: b = 16'd0;
        1: b = 16'hFFFF;
        2: a = 16'd0;
        3: a = 16'hFFFF;
        4: b = 16'($urandom_range(1, 15));
        default: ;
      endcase
      run_div(a, b, q, r, z, e, bn, bd, da);
      checks++;
      if (b == 16'd0) begin
        if ({q, r, z} !== {16'hFFFF, a, 1'b1} || e !== 0) begin
          failures++;
          $display("FAIL rand_%0d_div0: %h/%h got q=%h r=%h z=%b, expected q=ffff r=%h z=1", i, a, b, q, r, z, a);
        end
      end else begin
        prod = 32'(q) * 32'(b) + 32'(r);
        if (prod !== 32'(a) || r >= b || z !== 1'b0 || e !== 16) begin
          failures++;
          $display("FAIL rand_%0d: %h/%h got q=%h r=%h z=%b edge=%0d, expected q*d+r=%h r<d z=0 edge=16",
                   i, a, b, q, r, z, e, a);
        end
      end
    end
    $display("random: 2000 operand pairs checked");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
